// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult/div sequencing with
// HI/LO result registers, move-to-HI/LO, and a pipeline stall request.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_mdu,
  input  logic        sel_hi,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [31:0]        op_a, op_b;
  logic               op_sgn;
  logic               lat_en, hi_we, lo_we;
  logic [31:0]        hi_d, lo_d;

  // Datapath works only on latched operands, so the E-stage inputs are free
  // to change once the operation is accepted.
  logic [65:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

  // Multiply and divide results (sign-magnitude divide, truncate toward zero)
  always_comb begin
    mul_a = {{34{op_sgn & op_a[31]}}, op_a};
    mul_b = {{34{op_sgn & op_b[31]}}, op_b};
    prod  = mul_a * mul_b;
    a_neg = op_sgn & op_a[31];
    b_neg = op_sgn & op_b[31];
    a_mag = a_neg ? (~op_a + 32'd1) : op_a;
    b_mag = b_neg ? (~op_b + 32'd1) : op_b;
    // divisor forced nonzero only to keep the divider defined; the result is
    // discarded on divide-by-zero anyway
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem   = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  // Next-state, counter and HI/LO write decisions
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lat_en  = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_d    = hi;
    lo_d    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              state_n = MUL;
              cnt_n   = CNT_W'(MUL_CYCLES);
              lat_en  = 1'b1;
            end
            3'd2, 3'd3: begin
              state_n = DIV;
              cnt_n   = CNT_W'(DIV_CYCLES);
              lat_en  = 1'b1;
            end
            3'd4: begin
              hi_we = 1'b1;
              hi_d  = a;
            end
            3'd5: begin
              lo_we = 1'b1;
              lo_d  = a;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end
      end
      DIV: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          // divide-by-zero still burns the full latency but leaves HI/LO alone
          if (op_b != 32'd0) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            hi_d  = rem;
            lo_d  = quo;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter, operand latch and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sgn <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (lat_en) begin
        op_a   <= a;
        op_b   <= b;
        op_sgn <= ~op[0];
      end
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

  assign busy  = (state != IDLE);
  assign rdata = sel_hi ? hi : lo;
  // gated with reset so no stall leaks out while the unit is held in reset
  assign stall = reset & d_mdu & (busy | (start & (op <= 3'd3)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed mult/div/move results, latency,
// stall and reset behaviour.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        d_mdu = 1'b0;
  logic        sel_hi = 1'b0;
  logic [31:0] rdata, hi, lo;
  logic        busy, stall;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_mdu(d_mdu), .sel_hi(sel_hi), .rdata(rdata), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // pulse start for one cycle; returns at #1 into cycle t+1
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // expect busy for exactly n cycles with rdata holding its old value
  task automatic run_busy(input int n, input logic [31:0] pre_rd);
    for (int i = 0; i < n; i++) begin
      chk1("busy", busy, 1'b1);
      chk("rd_pre", rdata, pre_rd);
      @(posedge clk); #1;
    end
    chk1("idle_after", busy, 1'b0);
  endtask

  initial begin
    // reset state, with start/d_mdu active to confirm stall stays low
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd7; d_mdu = 1'b1;
    #12;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", stall, 1'b0);

    // release; first edge accepts signed mult -3*7
    reset = 1'b1;
    #1;
    chk1("stall_start", stall, 1'b1);
    @(posedge clk); #1;
    start = 1'b0; d_mdu = 1'b0;
    a = 32'h5555_5555; b = 32'h6666_6666;  // must not disturb result
    run_busy(5, 32'h0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    // multu 0xFFFFFFFF*2
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    run_busy(5, 32'hFFFF_FFEB);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7/2 then divu 7/2 back-to-back
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_busy(10, 32'hFFFF_FFFE);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd2);
    run_busy(10, 32'hFFFF_FFFD);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    sel_hi = 1'b1; #1;
    chk("rdata_hi", rdata, 32'd1);
    sel_hi = 1'b0; #1;
    chk("rdata_lo", rdata, 32'd3);

    // mthi / mtlo, each visible next cycle without busy
    issue(3'd4, 32'h12, 32'h0);
    chk("mthi_hi", hi, 32'h12);
    chk1("mthi_busy", busy, 1'b0);
    issue(3'd5, 32'h34, 32'h0);
    chk("mtlo_lo", lo, 32'h34);
    chk1("mtlo_busy", busy, 1'b0);

    // divide by zero: full latency, HI/LO untouched
    issue(3'd2, 32'd100, 32'd0);
    run_busy(10, 32'h34);
    chk("dz_hi", hi, 32'h12);
    chk("dz_lo", lo, 32'h34);

    // signed overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy(10, 32'h34);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // 7 / -2: quotient -3, remainder +1 (sign of dividend)
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    run_busy(10, 32'h8000_0000);
    chk("sdiv_lo", lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", hi, 32'd1);

    // mult 3*5 with d_mdu high; a divu 9/3 start mid-busy is ignored
    d_mdu = 1'b1;
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    #1;
    chk1("stall_issue", stall, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start = 1'b1; op = 3'd3; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      chk1("ign_busy", busy, 1'b1);
      chk1("ign_stall", stall, 1'b1);
      @(posedge clk); #1;
    end
    start = 1'b0; #1;
    chk1("ign_idle", busy, 1'b0);
    chk1("ign_stall_clr", stall, 1'b0);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd15);
    d_mdu = 1'b0;

    // async reset in cycle t+3 of a div
    issue(3'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk1("post_rst_idle", busy, 1'b0);
    chk("post_rst_lo", lo, 32'h0);

    // normal operation after reset: 6*7
    issue(3'd1, 32'd6, 32'd7);
    run_busy(5, 32'h0);
    chk("post_mul_lo", lo, 32'd42);
    chk("post_mul_hi", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
